// File: rtl/pio_pkg.sv
// Shared definitions for the Avalon-MM PIO blocks: register map and edge-type encoding.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Width of a counter that has to reach n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// Single-bit debouncer: stable follows the synchronised input only after the
// new level has been seen for DEBOUNCE_CYCLES consecutive clocks. With
// DEBOUNCE_CYCLES = 0 it degenerates to a wire.
module pio_in_debounce
  import pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic primed,
  input  logic sync1,
  input  logic sync2,
  output logic stable
);

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_pass
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset_n, primed, sync1};
      assign stable = sync2;
    end else begin : g_debounce
      localparam int CW = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] count;
      logic          stable_q;

      // While priming, stable takes the value sync2 is loading on the same
      // edge so both agree once priming ends; afterwards count disagreeing clocks.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count    <= '0;
          stable_q <= 1'b0;
        end else if (!primed) begin
          count    <= '0;
          stable_q <= sync1;
        end else if (sync2 == stable_q) begin
          count <= '0;
        end else if (count == LAST) begin
          stable_q <= sync2;
          count    <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end

      assign stable = stable_q;
    end
  endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronises and optionally debounces in_port, exposes
// the level, latches edges into write-1-to-clear sticky bits and drives a
// registered, maskable level interrupt.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int          WIDTH           = 8,
  parameter int          EDGE_TYPE       = 0,
  parameter int          DEBOUNCE_CYCLES = 0,
  parameter logic [31:0] RESET_MASK      = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [1:0]       prime_cnt;
  logic             primed;
  logic             wr_strobe;
  logic             unused_wdata;

  assign wr_strobe    = chipselect & ~write_n;
  assign unused_wdata = &{1'b0, writedata};

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Priming: hold off edge detection until sync2 carries real input data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= 2'd0;
      primed    <= 1'b0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 2'd1;
      primed    <= (prime_cnt == 2'd1);
    end
  end

  // Sync stage boundary -> stable level (debounced or pass-through per bit).
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .primed (primed),
      .sync1  (sync1[i]),
      .sync2  (sync2[i]),
      .stable (stable[i])
    );
  end

  // Previous stable level; during priming it tracks what sync2 loads so no
  // edge is seen on inputs that were already high at reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else if (!primed) begin
      prev <= sync1;
    end else begin
      prev <= stable;
    end
  end

  generate
    if (EDGE_TYPE == int'(EDGE_RISE)) begin : g_rise
      assign sel = stable & ~prev;
    end else if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_fall
      assign sel = ~stable & prev;
    end else begin : g_any
      assign sel = stable ^ prev;
    end
  endgenerate

  assign clr = (wr_strobe && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // Sticky edge bits; a new edge in the same clock as its clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (primed ? sel : '0) | (edge_capture & ~clr);
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= RESET_MASK[WIDTH-1:0];
    end else if (wr_strobe && (address == ADDR_MASK)) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Registered level interrupt from any unmasked captured edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_capture & irq_mask);
    end
  end

  // Zero-wait-state readback mux.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = stable;
      ADDR_RSVD: readdata = '0;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
    endcase
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: three instances (N=0 rising, N=4 any-edge with a
// non-zero reset mask, N=0 falling) share one bus and one input bus, each
// followed by a behavioural model; directed table plus hand-written sequences.
module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_port = 8'hFF;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .RESET_MASK(32'h00)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4), .RESET_MASK(32'h81)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0), .RESET_MASK(32'h00)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

  // Reference model: per instance, the input delayed two clocks, the level it
  // settles to (after N identical sightings), sticky edges, mask and irq.
  int         NDB [3] = '{0, 4, 0};
  int         ET  [3] = '{0, 2, 1};
  logic [7:0] RM  [3] = '{8'h00, 8'h81, 8'h00};
  logic [7:0] m_s1 [3];
  logic [7:0] m_s2 [3];
  logic [7:0] m_stab [3];
  logic [7:0] m_prev [3];
  logic [7:0] m_cap [3];
  logic [7:0] m_mask [3];
  logic       m_irq [3];
  int         m_prime [3];
  logic [7:0] m_hist [3][8];
  int         m_hcnt [3];

  function automatic logic [31:0] get_rd(int d);
    case (d)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic get_irq(int d);
    case (d)
      0:       return irq0;
      1:       return irq1;
      default: return irq2;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(int d, logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_stab[d]};
      2'd2:    return {24'd0, m_mask[d]};
      2'd3:    return {24'd0, m_cap[d]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_s1[d] = 8'h00; m_s2[d] = 8'h00; m_stab[d] = 8'h00; m_prev[d] = 8'h00;
      m_cap[d] = 8'h00; m_mask[d] = RM[d]; m_irq[d] = 1'b0; m_prime[d] = 2; m_hcnt[d] = 0;
    end
  endtask

  task automatic model_step();
    logic       wr;
    logic       primed_b;
    logic       held;
    logic [7:0] clr;
    logic [7:0] sel;
    logic [7:0] nstab;
    wr = chipselect && !write_n;
    for (int d = 0; d < 3; d++) begin
      clr = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
      primed_b = (m_prime[d] == 0);
      case (ET[d])
        0:       sel = m_stab[d] & ~m_prev[d];
        1:       sel = ~m_stab[d] & m_prev[d];
        default: sel = m_stab[d] ^ m_prev[d];
      endcase
      m_irq[d] = |(m_cap[d] & m_mask[d]);
      m_cap[d] = (primed_b ? sel : 8'h00) | (m_cap[d] & ~clr);
      if (wr && address == 2'd2) m_mask[d] = writedata[7:0];
      if (!primed_b) begin
        m_prev[d] = m_s1[d];
        m_stab[d] = m_s1[d];
        m_hcnt[d] = 0;
        m_prime[d] = m_prime[d] - 1;
      end else begin
        m_prev[d] = m_stab[d];
        if (NDB[d] == 0) begin
          m_stab[d] = m_s1[d];
        end else begin
          for (int j = 7; j > 0; j--) m_hist[d][j] = m_hist[d][j-1];
          m_hist[d][0] = m_s2[d];
          if (m_hcnt[d] < 8) m_hcnt[d] = m_hcnt[d] + 1;
          nstab = m_stab[d];
          for (int b = 0; b < 8; b++) begin
            held = (m_hcnt[d] >= NDB[d]);
            for (int j = 0; j < NDB[d]; j++)
              if (m_hist[d][j][b] == m_stab[d][b]) held = 1'b0;
            if (held) nstab[b] = ~m_stab[d][b];
          end
          m_stab[d] = nstab;
        end
      end
      m_s2[d] = m_s1[d];
      m_s1[d] = in_port;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("model_rd_dut%0d_a%0d", d, address), get_rd(d), exp_rd(d, address));
      chk($sformatf("model_irq_dut%0d", d), {31'd0, get_irq(d)}, {31'd0, m_irq[d]});
    end
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic peek(int d, logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = get_rd(d);
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic mid_reset();
    #1 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic [1:0]  a;
    logic        wr;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tbl [24];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;

    // Directed vectors for instance 0 (N=0, rising); row applied before an edge,
    // expectations are what dut0 shows after that edge.
    tbl[0]  = '{2'd0, 1'b0, 32'h0,        8'hFF, 32'h00, 1'b0};
    tbl[1]  = '{2'd0, 1'b0, 32'h0,        8'hFF, 32'hFF, 1'b0};
    tbl[2]  = '{2'd3, 1'b0, 32'h0,        8'hFF, 32'h00, 1'b0};
    tbl[3]  = '{2'd0, 1'b0, 32'h0,        8'h00, 32'hFF, 1'b0};
    tbl[4]  = '{2'd0, 1'b0, 32'h0,        8'h00, 32'h00, 1'b0};
    tbl[5]  = '{2'd3, 1'b0, 32'h0,        8'h00, 32'h00, 1'b0};
    tbl[6]  = '{2'd0, 1'b0, 32'h0,        8'h05, 32'h00, 1'b0};
    tbl[7]  = '{2'd0, 1'b0, 32'h0,        8'h05, 32'h05, 1'b0};
    tbl[8]  = '{2'd3, 1'b0, 32'h0,        8'h05, 32'h05, 1'b0};
    tbl[9]  = '{2'd2, 1'b1, 32'h04,       8'h05, 32'h04, 1'b0};
    tbl[10] = '{2'd2, 1'b0, 32'h0,        8'h05, 32'h04, 1'b1};
    tbl[11] = '{2'd3, 1'b1, 32'h04,       8'h05, 32'h01, 1'b1};
    tbl[12] = '{2'd3, 1'b0, 32'h0,        8'h05, 32'h01, 1'b0};
    tbl[13] = '{2'd3, 1'b1, 32'h01,       8'h04, 32'h00, 1'b0};
    tbl[14] = '{2'd0, 1'b0, 32'h0,        8'h04, 32'h04, 1'b0};
    tbl[15] = '{2'd0, 1'b0, 32'h0,        8'h05, 32'h04, 1'b0};
    tbl[16] = '{2'd0, 1'b0, 32'h0,        8'h05, 32'h05, 1'b0};
    tbl[17] = '{2'd3, 1'b1, 32'h01,       8'h05, 32'h01, 1'b0};
    tbl[18] = '{2'd3, 1'b1, 32'h01,       8'h05, 32'h00, 1'b0};
    tbl[19] = '{2'd3, 1'b0, 32'h0,        8'h05, 32'h00, 1'b0};
    tbl[20] = '{2'd0, 1'b1, 32'hFFFFFFFF, 8'h05, 32'h05, 1'b0};
    tbl[21] = '{2'd1, 1'b1, 32'hFFFFFFFF, 8'h05, 32'h00, 1'b0};
    tbl[22] = '{2'd2, 1'b0, 32'h0,        8'h05, 32'h04, 1'b0};
    tbl[23] = '{2'd3, 1'b0, 32'h0,        8'h05, 32'h00, 1'b0};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_irq0", {31'd0, irq0}, 32'd0);
    peek(1, 2'd2, v);
    chk("reset_mask_dut1", v, 32'h81);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      address = tbl[i].a; chipselect = tbl[i].wr; write_n = ~tbl[i].wr;
      writedata = tbl[i].wd; in_port = tbl[i].inp;
      cyc();
      chk($sformatf("tbl%0d_rd", i), rd0, tbl[i].rd);
      chk($sformatf("tbl%0d_irq", i), {31'd0, irq0}, {31'd0, tbl[i].irq});
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Debounce N=4 on dut1: a 3-clock pulse is rejected, a 4-clock hold is taken.
    cycles(10);
    bus_write(2'd3, 32'hFF);
    cycles(2);
    in_port = 8'h07;
    cycles(3);
    in_port = 8'h05;
    cycles(8);
    peek(1, 2'd0, v); chk("glitch_level_dut1", v, 32'h05);
    peek(1, 2'd3, v); chk("glitch_edge_dut1", v, 32'h00);
    in_port = 8'h07;
    cycles(5);
    peek(1, 2'd0, v); chk("hold_k4_level_dut1", v, 32'h05);
    cyc();
    peek(1, 2'd0, v); chk("hold_k5_level_dut1", v, 32'h07);
    peek(1, 2'd3, v); chk("hold_k5_edge_dut1", v, 32'h00);
    cyc();
    peek(1, 2'd3, v); chk("hold_k6_edge_dut1", v, 32'h02);

    // Edge type: bit7 rises then falls; any-edge sees both, falling only the fall.
    bus_write(2'd3, 32'hFF);
    in_port = 8'h87;
    cycles(8);
    peek(1, 2'd3, v); chk("rise_any_dut1", v, 32'h80);
    peek(2, 2'd3, v); chk("rise_fall_dut2", v, 32'h00);
    peek(0, 2'd3, v); chk("rise_rise_dut0", v, 32'h80);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h07;
    cycles(8);
    peek(1, 2'd3, v); chk("fall_any_dut1", v, 32'h80);
    peek(2, 2'd3, v); chk("fall_fall_dut2", v, 32'h80);
    peek(0, 2'd3, v); chk("fall_rise_dut0", v, 32'h00);

    // All bits captured with irq up, then reset mid-operation.
    in_port = 8'h00;
    cycles(8);
    bus_write(2'd3, 32'hFF);
    in_port = 8'hFF;
    cycles(8);
    peek(1, 2'd3, v); chk("pre_reset_edge_dut1", v, 32'hFF);
    chk("pre_reset_irq_dut1", {31'd0, irq1}, 32'd1);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_irq_dut0", {31'd0, irq0}, 32'd0);
    chk("async_irq_dut1", {31'd0, irq1}, 32'd0);
    peek(1, 2'd3, v); chk("async_edge_dut1", v, 32'h00);
    peek(1, 2'd2, v); chk("async_mask_dut1", v, 32'h81);
    @(negedge clk);
    reset_n = 1'b1;
    address = 2'd0;
    cycles(4);
    peek(0, 2'd0, v); chk("reprime_level_dut0", v, 32'hFF);
    peek(1, 2'd3, v); chk("reprime_edge_dut1", v, 32'h00);
    chk("reprime_irq_dut1", {31'd0, irq1}, 32'd0);

    // Randomised traffic against the model, with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) in_port = in_port ^ 8'($urandom);
      address = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n = ($urandom_range(0, 3) != 0);
      writedata = $urandom;
      if (i == 300) mid_reset();
      cyc();
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
